scan_column_driver: RTL and testbench

//  Parametrised column scanner for the multiplexed LED-matrix display.
//  - Steps through N_COLS columns; drives exactly one active one-hot column select per slot.
//  - Inserts a programmable blanking gap before each column to suppress ghosting.
//  - Divides the system clock to a configurable slot rate, with enable and frame-start pulse.
//  - Drives the column lines; row-data logic uses col_idx/frame_start to fetch pattern data.

---
 rtl/scan_column_driver.sv | 104 ++++++++++
 tb/tb_scan_column_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_column_driver.sv
// Column scanner for a multiplexed LED matrix.
// Each column owns a slot of DIV clocks: BLANK clocks with every column off,
// then the remaining clocks with only that column driven. col_idx and
// frame_start let the row-data logic fetch the pattern for the owning column.
// Valid/ready: none. The block is a free-running producer gated by en, and
// every output is a register that downstream logic samples on any clock.
module scan_column_driver #(
  parameter int N_COLS     = 5,
  parameter int DIV        = 50000,
  parameter int BLANK      = 4,
  parameter int ACTIVE_LOW = 0,
  localparam int COL_W     = $clog2(N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [N_COLS-1:0] col_sel,
  output logic [COL_W-1:0]  col_idx,
  output logic              blank,
  output logic              frame_start
);

  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(N_COLS - 1);
  localparam logic [N_COLS-1:0] SEL_OFF    = {N_COLS{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] slot_cnt;

  // Column drive pattern for a given column, in the configured polarity.
  function automatic logic [N_COLS-1:0] drive_sel(input logic [COL_W-1:0] idx);
    logic [N_COLS-1:0] oh;
    oh = {{(N_COLS-1){1'b0}}, 1'b1} << idx;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Wrapping successor of the current column; handles non-power-of-2 N_COLS.
  logic [COL_W-1:0] next_idx;
  always_comb begin
    next_idx = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
  end

  // Scan FSM: slot counter, column index and all registered outputs.
  // Dropping en or asserting rst returns to idle, so a restart is always column 0.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state       <= S_IDLE;
      slot_cnt    <= '0;
      col_idx     <= '0;
      col_sel     <= SEL_OFF;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // First slot of a scan is column 0, so it opens a frame.
          state       <= S_BLANK;
          slot_cnt    <= '0;
          col_idx     <= '0;
          col_sel     <= SEL_OFF;
          blank       <= 1'b1;
          frame_start <= 1'b1;
        end
        S_BLANK, S_DRIVE: begin
          if (slot_cnt == CNT_LAST) begin
            // Slot boundary: advance column and blank before driving it.
            state       <= S_BLANK;
            slot_cnt    <= '0;
            col_idx     <= next_idx;
            col_sel     <= SEL_OFF;
            blank       <= 1'b1;
            frame_start <= (next_idx == '0);
          end else begin
            slot_cnt    <= slot_cnt + CNT_W'(1);
            frame_start <= 1'b0;
            if (state == S_BLANK && slot_cnt == BLANK_LAST) begin
              state   <= S_DRIVE;
              col_sel <= drive_sel(col_idx);
              blank   <= 1'b0;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          slot_cnt    <= '0;
          col_idx     <= '0;
          col_sel     <= SEL_OFF;
          blank       <= 1'b1;
          frame_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_column_driver.sv
// Bench for scan_column_driver with DIV=8, BLANK=2 in three builds:
// 5 columns active-high, 3 columns active-high, 5 columns active-low.
// All three share clk/rst/en; a timing model predicts each build's outputs.
module tb_scan_column_driver;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [4:0] a_sel;  logic [2:0] a_idx;  logic a_blank, a_fs;
  logic [2:0] b_sel;  logic [1:0] b_idx;  logic b_blank, b_fs;
  logic [4:0] c_sel;  logic [2:0] c_idx;  logic c_blank, c_fs;

  scan_column_driver #(.N_COLS(5), .DIV(8), .BLANK(2), .ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .rst(rst), .en(en),
    .col_sel(a_sel), .col_idx(a_idx), .blank(a_blank), .frame_start(a_fs)
  );

  scan_column_driver #(.N_COLS(3), .DIV(8), .BLANK(2), .ACTIVE_LOW(0)) u_dut_b (
    .clk(clk), .rst(rst), .en(en),
    .col_sel(b_sel), .col_idx(b_idx), .blank(b_blank), .frame_start(b_fs)
  );

  scan_column_driver #(.N_COLS(5), .DIV(8), .BLANK(2), .ACTIVE_LOW(1)) u_dut_c (
    .clk(clk), .rst(rst), .en(en),
    .col_sel(c_sel), .col_idx(c_idx), .blank(c_blank), .frame_start(c_fs)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_a_q[$];
  logic [9:0] exp_b_q[$];
  logic [9:0] exp_c_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // timing model state: running flag and cycle number inside the scan
  bit run = 1'b0;
  int t   = 0;

  // capture of the first 80 scan cycles
  bit         cap_on = 1'b0;
  logic [9:0] cap_a[80];
  logic [4:0] cap_c[80];
  int         fs_a_cnt = 0;
  int         fs_b_cnt = 0;

  typedef struct {
    int         t;
    logic [4:0] sel;
    logic [2:0] idx;
    logic       bl;
    logic       fs;
    logic [4:0] al_sel;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Expected packed {frame_start, blank, idx[2:0], sel[4:0]} from scan position.
  function automatic logic [9:0] model(input int n, input bit al, input bit r, input int tt);
    logic [4:0] sel, mask;
    logic [2:0] idx;
    logic       bl, fs;
    int         col, off;
    mask = 5'((1 << n) - 1);
    if (!r) begin
      sel = al ? mask : 5'd0;
      idx = 3'd0;
      bl  = 1'b1;
      fs  = 1'b0;
    end else begin
      col = (tt / 8) % n;
      off = tt % 8;
      bl  = (off < 2);
      fs  = (off == 0) && (col == 0);
      idx = 3'(col);
      sel = bl ? 5'd0 : 5'(1 << col);
      if (al) sel = ~sel & mask;
    end
    return {fs, bl, idx, sel};
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of inputs, predict the result of the next edge, then
  // compare at the following falling edge.
  task automatic step(input logic r, input logic e);
    logic [9:0] got_a, got_b, got_c;
    logic [4:0] act_a, act_c;
    logic [2:0] act_b;
    rst = r;
    en  = e;
    if (r || !e) run = 1'b0;
    else if (!run) begin
      run = 1'b1;
      t   = 0;
    end else t++;
    exp_a_q.push_back(model(5, 1'b0, run, t));
    exp_b_q.push_back(model(3, 1'b0, run, t));
    exp_c_q.push_back(model(5, 1'b1, run, t));
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got_a = {a_fs, a_blank, a_idx, a_sel};
    got_b = {b_fs, b_blank, 1'b0, b_idx, 2'b00, b_sel};
    got_c = {c_fs, c_blank, c_idx, c_sel};
    check("out_a", 32'(got_a), 32'(exp_a_q.pop_front()));
    check("out_b", 32'(got_b), 32'(exp_b_q.pop_front()));
    check("out_c", 32'(got_c), 32'(exp_c_q.pop_front()));
    // one-hot invariant: at most one active column, none while blank
    act_a = a_sel;
    act_b = b_sel;
    act_c = ~c_sel;
    check("onehot_a", 32'($countones(act_a) <= 1 && !(a_blank && act_a != 0)), 32'd1);
    check("onehot_b", 32'($countones(act_b) <= 1 && !(b_blank && act_b != 0)), 32'd1);
    check("onehot_c", 32'($countones(act_c) <= 1 && !(c_blank && act_c != 0)), 32'd1);
    check("idx_b_range", 32'(b_idx < 2'd3), 32'd1);
    if (cap_on && run && t < 80) begin
      cap_a[t] = got_a;
      cap_c[t] = c_sel;
      if (a_fs) fs_a_cnt++;
      if (b_fs) fs_b_cnt++;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{0,  5'b00000, 3'd0, 1'b1, 1'b1, 5'b11111};
    vecs[1]  = '{1,  5'b00000, 3'd0, 1'b1, 1'b0, 5'b11111};
    vecs[2]  = '{2,  5'b00001, 3'd0, 1'b0, 1'b0, 5'b11110};
    vecs[3]  = '{7,  5'b00001, 3'd0, 1'b0, 1'b0, 5'b11110};
    vecs[4]  = '{8,  5'b00000, 3'd1, 1'b1, 1'b0, 5'b11111};
    vecs[5]  = '{10, 5'b00010, 3'd1, 1'b0, 1'b0, 5'b11101};
    vecs[6]  = '{18, 5'b00100, 3'd2, 1'b0, 1'b0, 5'b11011};
    vecs[7]  = '{26, 5'b01000, 3'd3, 1'b0, 1'b0, 5'b10111};
    vecs[8]  = '{34, 5'b10000, 3'd4, 1'b0, 1'b0, 5'b01111};
    vecs[9]  = '{40, 5'b00000, 3'd0, 1'b1, 1'b1, 5'b11111};
    vecs[10] = '{42, 5'b00001, 3'd0, 1'b0, 1'b0, 5'b11110};
    vecs[11] = '{79, 5'b10000, 3'd4, 1'b0, 1'b0, 5'b01111};

    rst = 1'b1;
    en  = 1'b1;

    // reset with en high: idle values
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("rst_sel", 32'(a_sel), 32'h00);
    check("rst_blank", 32'(a_blank), 32'd1);
    check("rst_fs", 32'(a_fs), 32'd0);
    check("rst_sel_al", 32'(c_sel), 32'h1f);

    // scan order, wrap and frame pulses over 80 cycles
    cap_on = 1'b1;
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1);
    cap_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("vec_sel",    32'(cap_a[vecs[i].t][4:0]), 32'(vecs[i].sel));
      check("vec_idx",    32'(cap_a[vecs[i].t][7:5]), 32'(vecs[i].idx));
      check("vec_blank",  32'(cap_a[vecs[i].t][8]),   32'(vecs[i].bl));
      check("vec_fs",     32'(cap_a[vecs[i].t][9]),   32'(vecs[i].fs));
      check("vec_al_sel", 32'(cap_c[vecs[i].t]),      32'(vecs[i].al_sel));
    end
    check("fs_count_5col", 32'(fs_a_cnt), 32'd2);
    check("fs_count_3col", 32'(fs_b_cnt), 32'd4);

    // enable toggle: drop en in cycle 19, then re-enable
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("pre_drop_idx", 32'(a_idx), 32'd2);
    step(1'b0, 1'b0);
    check("drop_sel", 32'(a_sel), 32'h00);
    check("drop_idx", 32'(a_idx), 32'd0);
    check("drop_blank", 32'(a_blank), 32'd1);
    step(1'b0, 1'b1);
    check("reen_fs", 32'(a_fs), 32'd1);
    check("reen_idx", 32'(a_idx), 32'd0);

    // reset mid-scan in cycle 13, held, then released with en high
    step(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("midrst_fs", 32'(a_fs), 32'd0);
    check("midrst_idx", 32'(a_idx), 32'd0);
    step(1'b1, 1'b1);
    check("midrst_hold_fs", 32'(a_fs), 32'd0);
    step(1'b0, 1'b1);
    check("rst_release_fs", 32'(a_fs), 32'd1);

    // random enable / reset traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 19) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
